// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multicycle restoring signed divider, MIPS DIV semantics (LO=quotient, HI=remainder)
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, hi_q, lo_q;
  logic [CW-1:0] cnt_q;
  logic sgn_q_q, sgn_r_q, done_q, dz_q;
  logic zero, accept, reject;
  logic [WIDTH:0] shifted, diff;
  assign zero = divisor_i == '0;
  assign accept = state_q == IDLE && start_i && !zero;
  assign reject = state_q == IDLE && start_i && zero;
  // one restoring step: the dividend shifts out of quo into rem as quotient bits shift in
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff = shifted - {1'b0, dvs_q};
  assign rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (accept ? CALC : IDLE) :
              state_q == CALC ? (cnt_q == CW'(WIDTH - 1) ? FIX : CALC) : IDLE;
  always_comb
    busy_o = state_q != IDLE || (done_q && !dz_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      done_q <= state_q == FIX || reject;
      dz_q <= reject;
      if (accept) begin
        quo_q <= dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
        dvs_q <= divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
        rem_q <= '0;
        cnt_q <= '0;
        sgn_q_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
        sgn_r_q <= dividend_i[WIDTH-1];
      end else if (state_q == CALC) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q + 1'b1;
      end else if (state_q == FIX) begin
        lo_q <= sgn_q_q ? -quo_q : quo_q;
        hi_q <= sgn_r_q ? -rem_q : rem_q;
      end
    end
  assign done_o = done_q;
  assign div_zero_o = dz_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: table vectors, corner sequences and random operands against an arithmetic model
module tb_seq_signed_divider;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int pass = 0, total = 0;
  logic [31:0] m_lo = 0, m_hi = 0;
  typedef struct {logic [31:0] a, b, lo, hi; logic dz;} vec_t;
  vec_t tbl[12];
  seq_signed_divider dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .dividend_i(dividend), .divisor_i(divisor),
    .busy_o(busy), .done_o(done), .div_zero_o(div_zero), .hi_o(hi), .lo_o(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", nm, got, exp);
    else pass++;
  endtask
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  // waits from one edge past E0 (lat0 edges already elapsed) to the done cycle and checks it
  task automatic finish(input string nm, input int lat0, input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
    int lat = lat0, bad = 0;
    while (!done && lat < 100) begin
      if (busy !== !edz) bad++;
      @(posedge clk);
      #1 lat++;
    end
    if (busy !== !edz) bad++;
    chk({nm, ".latency"}, lat, edz ? 0 : 33);
    chk({nm, ".div_zero"}, div_zero, edz);
    chk({nm, ".lo"}, lo, elo);
    chk({nm, ".hi"}, hi, ehi);
    chk({nm, ".busy"}, bad, 0);
    if (!edz) begin
      m_lo = elo;
      m_hi = ehi;
    end
  endtask
  initial begin
    tbl[0]  = '{32'd7, 32'd2, 32'd3, 32'd1, 1'b0};
    tbl[1]  = '{-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0};
    tbl[3]  = '{-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{32'd86, 32'd9, 32'd9, 32'd5, 1'b0};
    tbl[5]  = '{32'd123, 32'd0, 32'd9, 32'd5, 1'b1};
    tbl[6]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
    tbl[7]  = '{32'h80000000, 32'd1, 32'h80000000, 32'd0, 1'b0};
    tbl[8]  = '{32'd5, 32'h7FFFFFFF, 32'd0, 32'd5, 1'b0};
    tbl[9]  = '{32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0};
    tbl[10] = '{32'h7FFFFFFF, 32'h80000000, 32'd0, 32'h7FFFFFFF, 1'b0};
    tbl[11] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    repeat (2) @(posedge clk);
    #1 chk("reset", {busy, done, div_zero, hi, lo}, '0);
    @(negedge clk) rst_n = 1;
    foreach (tbl[i]) begin
      launch(tbl[i].a, tbl[i].b);
      finish($sformatf("vec%0d", i), 0, tbl[i].lo, tbl[i].hi, tbl[i].dz);
    end
    launch(32'd20, 32'd6);
    repeat (5) @(negedge clk);
    dividend = 32'd9;
    divisor = 32'd3;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    finish("ignored", 5, 32'd3, 32'd2, 1'b0);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    finish("b2b", 0, 32'd3, 32'd0, 1'b0);
    launch(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("mid_reset", {busy, done, div_zero, hi, lo}, '0);
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", {busy, done, div_zero, hi, lo}, '0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 chk("after_release", {busy, done, div_zero}, '0);
    launch(32'd100, 32'd7);
    finish("post_reset", 0, 32'd14, 32'd2, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b, elo, ehi;
      longint q, r;
      int sel = $urandom_range(0, 9);
      a = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      b = sel == 0 ? 32'd0 : sel < 4 ? 32'($signed($urandom_range(0, 15)) - 8) : sel == 4 ? 32'hFFFFFFFF : $urandom;
      if (b == 0) begin
        elo = m_lo;
        ehi = m_hi;
      end else begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        elo = q[31:0];
        ehi = r[31:0];
      end
      launch(a, b);
      finish($sformatf("rnd%0d", i), 0, elo, ehi, b == 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
